// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults and constant helpers for param_sync_fifo.
// Imported by the FIFO to derive its pointer and count widths.
package param_sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // $clog2 returns 0 for n<=1, which would produce zero-width vectors.
    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count and threshold flags.
// Define PARAM_SYNC_FIFO_ERR_EN to elaborate sticky ovf/udf flags and their error assertion.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_valid,
    input  logic [WIDTH-1:0]                   wr_data,
    output logic                               wr_ready,
    input  logic                               rd_ready,
    output logic                               rd_valid,
    output logic [WIDTH-1:0]                   rd_data,
    output logic [clog2_safe(DEPTH+1)-1:0]     count,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               ovf,
    output logic                               udf
);

    localparam int AW = clog2_safe(DEPTH);
    localparam int CW = clog2_safe(DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_THR   = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AE_THR   = CW'(AEMPTY_LVL);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [AW-1:0]    w_wr_ptr_next;
    logic [AW-1:0]    w_rd_ptr_next;

    // Ready/valid depend only on registered count, never on the opposite handshake input.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_wr_fire = wr_valid && !w_full;
    assign w_rd_fire = rd_ready && !w_empty;

    // Explicit wrap so depths that are not a power of two index correctly.
    assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= w_wr_ptr_next;
            if (w_rd_fire) r_rd_ptr <= w_rd_ptr_next;
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never presented as valid.
    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data      = r_mem[r_rd_ptr];
    assign wr_ready     = !w_full;
    assign rd_valid     = !w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= AF_THR);
    assign almost_empty = (r_count <= AE_THR);

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;
    logic w_ovf_evt;
    logic w_udf_evt;

    assign w_ovf_evt = wr_valid && w_full;
    assign w_udf_evt = rd_ready && w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_evt) r_ovf <= 1'b1;
            if (w_udf_evt) r_udf <= 1'b1;
        end
    end

    // Report only the first occurrence of each error; later ones are hidden by the sticky flag.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_ovf_evt && !r_ovf)) else $error("param_sync_fifo: overflow");
            assert (!(w_udf_evt && !r_udf)) else $error("param_sync_fifo: underflow");
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
